// File: rtl/button_counter_in.sv
// Push-button front end for the LED counter: synchronise, debounce and
// auto-repeat three buttons, and keep an 8-bit up/down/clear count.
module button_counter_in #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1,
  parameter logic [7:0]  INIT_VALUE      = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       btn_clr_raw,
  output logic [7:0] count,
  output logic       up_pulse,
  output logic       down_pulse,
  output logic       clr_pulse,
  output logic [2:0] btn_level
);

  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RDW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int RPW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int TW  = (RDW > RPW) ? RDW : RPW;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LOAD  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  logic [2:0] raw;
  logic [2:0] lvl;
  logic [2:0] lvl_next;
  logic [2:0] press;
  logic [1:0] rpt;

  assign raw = {btn_clr_raw, btn_down_raw, btn_up_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic          meta_q, sync_q, pressed_q;
      logic          level_q, level_d;
      logic [DW-1:0] cnt_q, cnt_d;

      // Counter only runs while the filtered input disagrees with the level.
      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (pressed_q != level_q) begin
          if (cnt_q == DB_LAST) level_d = ~level_q;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_q    <= BTN_ACTIVE_LOW;
          sync_q    <= BTN_ACTIVE_LOW;
          pressed_q <= 1'b0;
          level_q   <= 1'b0;
          cnt_q     <= '0;
        end else begin
          meta_q    <= raw[gi];
          sync_q    <= meta_q;
          pressed_q <= sync_q ^ BTN_ACTIVE_LOW;
          level_q   <= level_d;
          cnt_q     <= cnt_d;
        end
      end

      assign lvl[gi]      = level_q;
      assign lvl_next[gi] = level_d;
      assign press[gi]    = level_d & ~level_q;
    end

    for (gi = 0; gi < 2; gi++) begin : g_rpt
      rpt_state_t    state_q, state_d;
      logic [TW-1:0] timer_q, timer_d;
      logic          rpt_d;

      // A release seen on this edge wins over a repeat pulse due on it.
      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rpt_d   = 1'b0;
        case (state_q)
          RPT_IDLE: begin
            if (press[gi] && (REPEAT_DELAY != 0)) begin
              state_d = RPT_DELAY;
              timer_d = DELAY_LOAD;
            end
          end
          RPT_DELAY, RPT_REPEAT: begin
            if (!lvl_next[gi]) begin
              state_d = RPT_IDLE;
              timer_d = '0;
            end else if (timer_q == '0) begin
              rpt_d   = 1'b1;
              state_d = RPT_REPEAT;
              timer_d = PERIOD_LOAD;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
          default: begin
            state_d = RPT_IDLE;
            timer_d = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= RPT_IDLE;
          timer_q <= '0;
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
        end
      end

      assign rpt[gi] = rpt_d;
    end
  endgenerate

  logic       up_d, down_d, clr_d;
  logic       up_q, down_q, clr_q;
  logic [7:0] count_d, count_q;

  assign up_d   = press[0] | rpt[0];
  assign down_d = press[1] | rpt[1];
  assign clr_d  = press[2];

  always_comb begin
    count_d = count_q;
    if (clr_d)                count_d = 8'h00;
    else if (up_d && !down_d) count_d = count_q + 8'd1;
    else if (down_d && !up_d) count_d = count_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      clr_q   <= 1'b0;
      count_q <= INIT_VALUE;
    end else begin
      up_q    <= up_d;
      down_q  <= down_d;
      clr_q   <= clr_d;
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign up_pulse   = up_q;
  assign down_pulse = down_q;
  assign clr_pulse  = clr_q;
  assign btn_level  = lvl;

endmodule

// File: tb/tb_button_counter_in.sv
// Directed bench for button_counter_in with short debounce/repeat timings.
module tb_button_counter_in;

  logic       clk;
  logic       rst_n;
  logic       btn_up_raw, btn_down_raw, btn_clr_raw;
  logic [7:0] count;
  logic       up_pulse, down_pulse, clr_pulse;
  logic [2:0] btn_level;

  int n_cmp = 0;
  int n_err = 0;

  button_counter_in #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .BTN_ACTIVE_LOW (1'b1),
    .INIT_VALUE     (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up_raw  (btn_up_raw),
    .btn_down_raw(btn_down_raw),
    .btn_clr_raw (btn_clr_raw),
    .count       (count),
    .up_pulse    (up_pulse),
    .down_pulse  (down_pulse),
    .clr_pulse   (clr_pulse),
    .btn_level   (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press the selected buttons cleanly, check the accept edge, then release.
  task automatic press(input bit u, input bit d, input bit c, input logic [7:0] exp_count);
    btn_up_raw   = !u;
    btn_down_raw = !d;
    btn_clr_raw  = !c;
    step(6);
    chk("press_early_pulses", {clr_pulse, down_pulse, up_pulse}, 3'b000);
    step(1);
    chk("press_pulses", {clr_pulse, down_pulse, up_pulse}, {c, d, u});
    chk("press_level", btn_level, {c, d, u});
    chk("press_count", count, exp_count);
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    btn_clr_raw  = 1'b1;
    step(9);
    chk("release_level", btn_level, 3'b000);
    chk("release_count", count, exp_count);
    $display("press u=%0d d=%0d c=%0d -> count=%0d", u, d, c, count);
  endtask

  initial begin
    logic       exp_up;
    int         exp_cnt;
    logic [7:0] exp8;
    bit         found;

    rst_n        = 1'b0;
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    btn_clr_raw  = 1'b1;
    step(2);
    chk("reset_count", count, 8'h00);
    chk("reset_pulses", {clr_pulse, down_pulse, up_pulse}, 3'b000);
    chk("reset_level", btn_level, 3'b000);
    rst_n = 1'b1;
    step(3);
    chk("idle_count", count, 8'h00);
    $display("reset done count=%0d", count);

    // Press at edge 6, repeats at 16..34, release seen at edge 37 cancels the due repeat
    exp_cnt    = 0;
    btn_up_raw = 1'b0;
    for (int e = 0; e <= 45; e++) begin
      step(1);
      exp_up = (e == 6) || (e >= 16 && e <= 34 && ((e - 16) % 3) == 0);
      if (exp_up) exp_cnt++;
      chk("hold_up_pulse", up_pulse, exp_up);
      chk("hold_down_pulse", down_pulse, 1'b0);
      chk("hold_level", btn_level, (e >= 6 && e < 37) ? 3'b001 : 3'b000);
      chk("hold_count", count, exp_cnt);
      if (e == 30) btn_up_raw = 1'b1;
    end
    chk("hold_final_count", count, 8'd8);
    $display("auto-repeat hold done count=%0d", count);
    step(5);

    press(1'b0, 1'b0, 1'b1, 8'd0);
    press(1'b0, 1'b1, 1'b0, 8'd255);
    exp8 = 8'd255;
    for (int i = 0; i < 256; i++) begin
      exp8 = exp8 + 8'd1;
      press(1'b1, 1'b0, 1'b0, exp8);
    end
    chk("wrap_count", count, 8'd255);

    // Three-cycle glitches on all pads never get through the filter
    for (int r = 0; r < 4; r++) begin
      btn_up_raw   = 1'b0;
      btn_down_raw = 1'b0;
      btn_clr_raw  = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step(1);
        chk("glitch_level", btn_level, 3'b000);
        chk("glitch_pulses", {clr_pulse, down_pulse, up_pulse}, 3'b000);
      end
      btn_up_raw   = 1'b1;
      btn_down_raw = 1'b1;
      btn_clr_raw  = 1'b1;
      for (int k = 0; k < 3; k++) begin
        step(1);
        chk("glitch_level", btn_level, 3'b000);
        chk("glitch_pulses", {clr_pulse, down_pulse, up_pulse}, 3'b000);
      end
    end
    step(8);
    chk("glitch_level_end", btn_level, 3'b000);
    chk("glitch_count", count, 8'd255);
    $display("glitch train done count=%0d", count);

    press(1'b1, 1'b1, 1'b0, 8'd255);
    press(1'b1, 1'b0, 1'b1, 8'd0);

    // Hold up into the repeat phase until count reaches 37, then reset mid-cycle
    btn_up_raw = 1'b0;
    found      = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step(1);
      if (count == 8'd37) found = 1'b1;
    end
    chk("reach_37", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 8'h00);
    chk("async_rst_pulses", {clr_pulse, down_pulse, up_pulse}, 3'b000);
    chk("async_rst_level", btn_level, 3'b000);
    step(2);
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      step(1);
      chk("post_rst_pulse", up_pulse, e == 6);
      chk("post_rst_count", count, (e == 6) ? 8'd1 : 8'd0);
    end
    $display("reset mid-repeat done count=%0d", count);
    btn_up_raw = 1'b1;
    step(12);
    chk("final_level", btn_level, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
